// File: rtl/clkgate_seq.sv
// Edge-gate enable sequencer: free-run, halt and counted step bursts for the debug path.
// Define CLKGATE_SEQ_EDGE_COUNT_EN to add the 32-bit 'edges' counter of gated edges passed.
module clkgate_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  input  logic [CNT_W-1:0] step_n,
  output logic             en,
  output logic             busy,
  output logic             done
`ifdef CLKGATE_SEQ_EDGE_COUNT_EN
  ,
  output logic [31:0]      edges
`endif
);

  localparam logic [1:0] S_HALTED  = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_BURST   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Request priority is halt > run > step; cnt holds the edges left after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_HALTED: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (run) begin
          state_d = S_RUNNING;
        end else if (step) begin
          if (step_n != '0) begin
            state_d = S_BURST;
            cnt_d   = step_n - CNT_W'(1);
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_RUNNING: begin
        if (halt) begin
          state_d = S_HALTED;
        end
      end
      S_BURST: begin
        if (halt) begin
          state_d = S_HALTED;
          cnt_d   = '0;
        end else if (run) begin
          state_d = S_RUNNING;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_HALTED;
        cnt_d   = '0;
      end
    endcase
    en_d   = (state_d != S_HALTED);
    busy_d = (state_d != S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HALTED;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CLKGATE_SEQ_EDGE_COUNT_EN
  logic [31:0] edges_q;

  // A gated edge passes on every rising edge that sees the registered enable high.
  always_ff @(posedge clk) begin
    if (rst) begin
      edges_q <= 32'd0;
    end else if (en_q) begin
      edges_q <= edges_q + 32'd1;
    end
  end

  assign edges = edges_q;
`endif

endmodule

// File: tb/tb_clkgate_seq.sv
// Scoreboard bench for clkgate_seq: a cycle model queues expected outputs per driven cycle.
// Builds with or without CLKGATE_SEQ_EDGE_COUNT_EN.
module tb_clkgate_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  step_n = 8'd0;
  logic        en, busy, done;
`ifdef CLKGATE_SEQ_EDGE_COUNT_EN
  logic [31:0] edges;
`endif

  int checks = 0;
  int errors = 0;
  int gatedEdges = 0;
  int donePulses = 0;

  int          mState = 0;
  int          mLen = 0;
  int          mPassed = 0;
  bit          mDone = 1'b0;
  int unsigned mEdges = 0;
  logic [34:0] expQ[$];

  clkgate_seq #(.CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .halt(halt),
    .step(step),
    .step_n(step_n),
    .en(en),
    .busy(busy),
    .done(done)
`ifdef CLKGATE_SEQ_EDGE_COUNT_EN
    ,
    .edges(edges)
`endif
  );

  always #5 clk = ~clk;

  // en sampled in the low phase decides whether the following rising edge is gated through
  always @(negedge clk) begin
    if (en === 1'b1) gatedEdges++;
    if (done === 1'b1) donePulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Burst tracked as length plus edges already granted
  task automatic modelStep(input bit r, input bit rn, input bit h, input bit s, input int n);
    bit prevEn;
    prevEn = (mState != 0);
    if (r) begin
      mState = 0; mLen = 0; mPassed = 0; mDone = 1'b0; mEdges = 0;
    end else begin
      if (prevEn) mEdges++;
      mDone = 1'b0;
      case (mState)
        0: begin
          if (h) mState = 0;
          else if (rn) mState = 1;
          else if (s) begin
            if (n == 0) mDone = 1'b1;
            else begin mState = 2; mLen = n; mPassed = 1; end
          end
        end
        1: if (h) mState = 0;
        default: begin
          if (h) mState = 0;
          else if (rn) mState = 1;
          else if (mPassed == mLen) begin mState = 0; mDone = 1'b1; end
          else mPassed++;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rn, input bit h, input bit s, input int n);
    logic [34:0] exp;
    logic        mEn;
    @(negedge clk);
    rst = r; run = rn; halt = h; step = s; step_n = n[7:0];
    modelStep(r, rn, h, s, n);
    mEn = (mState != 0);
    expQ.push_back({mEdges, mEn, mEn, mDone});
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    checkOutput("en", {31'd0, en}, {31'd0, exp[2]});
    checkOutput("busy", {31'd0, busy}, {31'd0, exp[1]});
    checkOutput("done", {31'd0, done}, {31'd0, exp[0]});
    checkOutput("doneWithEn", {31'd0, done & en}, 32'd0);
`ifdef CLKGATE_SEQ_EDGE_COUNT_EN
    checkOutput("edges", edges, exp[34:3]);
`endif
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int g0, d0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    g0 = gatedEdges; d0 = donePulses;
    idle(10);
    checkOutput("idleEdges", gatedEdges - g0, 0);
    checkOutput("idleDone", donePulses - d0, 0);

    g0 = gatedEdges; d0 = donePulses;
    applyStimulus(0, 0, 0, 1, 3);
    idle(5);
    checkOutput("burst3Edges", gatedEdges - g0, 3);
    checkOutput("burst3Done", donePulses - d0, 1);

    g0 = gatedEdges; d0 = donePulses;
    applyStimulus(0, 0, 0, 1, 0);
    idle(3);
    checkOutput("burst0Edges", gatedEdges - g0, 0);
    checkOutput("burst0Done", donePulses - d0, 1);

    g0 = gatedEdges; d0 = donePulses;
    applyStimulus(0, 0, 0, 1, 200);
    idle(4);
    applyStimulus(0, 0, 1, 0, 0);
    idle(3);
    checkOutput("haltBurstEdges", gatedEdges - g0, 5);
    checkOutput("haltBurstDone", donePulses - d0, 0);

    g0 = gatedEdges; d0 = donePulses;
    applyStimulus(0, 1, 0, 0, 0);
    idle(19);
    applyStimulus(0, 0, 1, 1, 4);
    idle(3);
    checkOutput("runHaltEdges", gatedEdges - g0, 20);
    checkOutput("runHaltDone", donePulses - d0, 0);

    d0 = donePulses;
    applyStimulus(0, 0, 0, 1, 255);
    idle(10);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rstAbortDone", donePulses - d0, 0);
    g0 = gatedEdges; d0 = donePulses;
    applyStimulus(0, 0, 0, 1, 1);
    idle(3);
    checkOutput("afterRstEdges", gatedEdges - g0, 1);
    checkOutput("afterRstDone", donePulses - d0, 1);

    g0 = gatedEdges; d0 = donePulses;
    applyStimulus(0, 0, 0, 1, 255);
    idle(258);
    checkOutput("burst255Edges", gatedEdges - g0, 255);
    checkOutput("burst255Done", donePulses - d0, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                    int'($urandom_range(0, 6)));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
